// File: rtl/fetch_stage_if.sv
// Fetch stage bus bundle: instruction-memory request/response plus the
// decode-side valid/ready handshake and the execute redirect.
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    // Seen from the fetch stage.
    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  redirect, redirect_pc,
        output instr_valid, instr, instr_pc,
        input  instr_ready
    );

    // Seen from memory, execute and decode.
    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output redirect, redirect_pc,
        input  instr_valid, instr, instr_pc,
        output instr_ready
    );
endinterface

// File: rtl/fetch_stage.sv
// RV32I instruction fetch stage: owns the PC, keeps at most FIFO_DEPTH words
// either in flight or buffered, and hands them to decode in order.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic          clk,
    input logic          rstn,
    fetch_stage_if.master bus
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef logic [CW-1:0] cnt_t;
    typedef logic [PW-1:0] ptr_t;

    logic [31:0] pc_q, pc_d;
    logic [31:0] resp_pc_q, resp_pc_d;
    cnt_t        outst_q, outst_d;
    cnt_t        discard_q, discard_d;
    cnt_t        count_q, count_d;
    ptr_t        wptr_q, wptr_d;
    ptr_t        rptr_q, rptr_d;
    logic        req_en_q, req_en_d;
    logic [63:0] mem_q [FIFO_DEPTH];

    logic [CW:0] in_use;
    logic        fire;
    logic        push;
    logic        pop;
    logic [31:0] tgt;

    // Handshake outputs; the credit check uses registered counts only.
    always_comb begin
        in_use          = {1'b0, outst_q} + {1'b0, count_q};
        bus.imem_req    = req_en_q & ~bus.redirect & (in_use < (CW + 1)'(FIFO_DEPTH));
        bus.imem_addr   = {pc_q[31:2], 2'b00};
        bus.instr_valid = (count_q != '0);
        bus.instr       = bus.instr_valid ? mem_q[rptr_q][63:32] : 32'h0;
        bus.instr_pc    = bus.instr_valid ? mem_q[rptr_q][31:0]  : 32'h0;
        fire            = bus.imem_req & bus.imem_gnt;
        pop             = bus.instr_valid & bus.instr_ready;
        tgt             = {bus.redirect_pc[31:2], 2'b00};
    end

    // Next-state: PC, in-flight accounting, discard of stale responses, FIFO pointers.
    always_comb begin
        pc_d      = pc_q;
        resp_pc_d = resp_pc_q;
        outst_d   = outst_q;
        discard_d = discard_q;
        count_d   = count_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        req_en_d  = 1'b1;
        push      = 1'b0;

        if (fire && !bus.imem_rvalid) begin
            outst_d = outst_q + cnt_t'(1);
        end else if (!fire && bus.imem_rvalid) begin
            outst_d = outst_q - cnt_t'(1);
        end
        if (fire) begin
            pc_d = pc_q + 32'd4;
        end

        if (bus.redirect) begin
            // Everything still in flight after this cycle belongs to the old path.
            pc_d      = tgt;
            resp_pc_d = tgt;
            discard_d = outst_d;
            count_d   = '0;
            wptr_d    = '0;
            rptr_d    = '0;
        end else begin
            if (bus.imem_rvalid) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - cnt_t'(1);
                end else begin
                    push      = 1'b1;
                    resp_pc_d = resp_pc_q + 32'd4;
                end
            end
            if (push) wptr_d = wptr_q + ptr_t'(1);
            if (pop)  rptr_d = rptr_q + ptr_t'(1);
            count_d = count_q + cnt_t'(push) - cnt_t'(pop);
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pc_q      <= RESET_PC;
            resp_pc_q <= RESET_PC;
            outst_q   <= '0;
            discard_q <= '0;
            count_q   <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            req_en_q  <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            resp_pc_q <= resp_pc_d;
            outst_q   <= outst_d;
            discard_q <= discard_d;
            count_q   <= count_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            req_en_q  <= req_en_d;
        end
    end

    // Buffer storage; contents are only visible through count_q, so no reset.
    always_ff @(posedge clk) begin
        if (push && rstn) begin
            mem_q[wptr_q] <= {bus.imem_rdata, resp_pc_q};
        end
    end

    a_rvalid_outst : assert property (@(posedge clk) disable iff (!rstn)
        bus.imem_rvalid |-> (outst_q != '0));
    a_fifo_bound : assert property (@(posedge clk) disable iff (!rstn)
        count_q <= cnt_t'(FIFO_DEPTH));
    a_addr_align : assert property (@(posedge clk) disable iff (!rstn)
        bus.imem_addr[1:0] == 2'b00);
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: in-order memory with random grant/latency, random
// decode backpressure, redirects and resets, checked every cycle against a
// queue-level model of granted and buffered words.
module tb_fetch_stage;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic clk;
    logic rstn;
    fetch_stage_if bus ();

    fetch_stage #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          gcyc;
        bit          stale;
    } pend_t;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Model state.
    pend_t       pend[$];
    logic [31:0] bq[$];
    logic [31:0] fetch_pc;
    bit          req_en;
    bit          known = 0;
    int          grants;

    // Stimulus knobs.
    int          gnt_pct = 100, rv_pct = 100, rdy_pct = 100, redir_pm = 0, rst_pm = 0;
    bit          rst_knob = 1'b1;
    bit          force_redir = 1'b0;
    logic [31:0] force_tgt = 32'h0;

    // Sampled outputs and pop log.
    logic        o_req, o_valid;
    logic [31:0] o_addr, o_instr, o_pc;
    bit          pop_seen;
    logic [31:0] last_pop_pc, last_pop_instr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance the model.
    task automatic step();
        bit          exp_req, fire, do_push;
        logic [31:0] push_addr;
        pend_t       e;
        @(negedge clk);
        cyc++;
        rstn = !(rst_knob || ($urandom_range(0, 999) < rst_pm));
        if (!rstn) begin
            bus.imem_gnt    = 1'b0;
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = $urandom;
            bus.redirect    = 1'b0;
            bus.redirect_pc = $urandom;
            bus.instr_ready = 1'b0;
        end else begin
            bus.imem_gnt    = ($urandom_range(0, 99) < gnt_pct);
            bus.imem_rvalid = (pend.size() > 0) && (pend[0].gcyc < cyc)
                              && ($urandom_range(0, 99) < rv_pct);
            bus.imem_rdata  = bus.imem_rvalid ? mem_word(pend[0].addr) : $urandom;
            bus.redirect    = force_redir || ($urandom_range(0, 999) < redir_pm);
            bus.redirect_pc = force_redir ? force_tgt : $urandom;
            bus.instr_ready = ($urandom_range(0, 99) < rdy_pct);
        end
        force_redir = 1'b0;
        #1;
        exp_req = req_en && !bus.redirect && (pend.size() + bq.size() < DEPTH);
        if (known) begin
            chk("imem_req", {31'b0, bus.imem_req}, {31'b0, exp_req});
            if (exp_req) chk("imem_addr", bus.imem_addr, fetch_pc);
            chk("instr_valid", {31'b0, bus.instr_valid}, {31'b0, bq.size() > 0});
            chk("instr_pc", bus.instr_pc, bq.size() > 0 ? bq[0] : 32'h0);
            chk("instr", bus.instr, bq.size() > 0 ? mem_word(bq[0]) : 32'h0);
        end
        o_req   = bus.imem_req;
        o_addr  = bus.imem_addr;
        o_valid = bus.instr_valid;
        o_instr = bus.instr;
        o_pc    = bus.instr_pc;
        if (rstn && !bus.redirect && o_valid && bus.instr_ready && !pop_seen) begin
            pop_seen       = 1'b1;
            last_pop_pc    = o_pc;
            last_pop_instr = o_instr;
        end
        if (!rstn) begin
            pend.delete();
            bq.delete();
            fetch_pc = RPC;
            req_en   = 1'b0;
            known    = 1'b1;
            grants   = 0;
        end else if (known) begin
            fire    = exp_req && bus.imem_gnt;
            do_push = 1'b0;
            if (bus.imem_rvalid) begin
                e = pend.pop_front();
                if (!bus.redirect && !e.stale) begin
                    do_push   = 1'b1;
                    push_addr = e.addr;
                end
            end
            if (bus.redirect) begin
                bq.delete();
                foreach (pend[i]) pend[i].stale = 1'b1;
                fetch_pc = {bus.redirect_pc[31:2], 2'b00};
            end else begin
                if (bus.instr_ready && bq.size() > 0) void'(bq.pop_front());
                if (do_push) bq.push_back(push_addr);
            end
            if (fire) begin
                pend.push_back('{addr: fetch_pc, gcyc: cyc, stale: 1'b0});
                fetch_pc = fetch_pc + 32'd4;
                grants++;
            end
            req_en = 1'b1;
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Wait for the next accepted instruction, bounded.
    task automatic wait_pop(input string name);
        int n;
        pop_seen = 1'b0;
        n = 0;
        while (!pop_seen && n < 60) begin
            step();
            n++;
        end
        if (!pop_seen) begin
            checks++;
            failures++;
            $display("FAIL %s got=no_pop exp=pop_within_60_cycles", name);
        end
    endtask

    task automatic do_reset();
        rst_knob = 1'b1;
        steps(2);
        rst_knob = 1'b0;
    endtask

    initial begin
        rstn            = 1'b0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.instr_ready = 1'b0;

        // Reset values.
        rst_knob = 1'b1;
        steps(3);
        chk("rst_req", {31'b0, o_req}, 32'd0);
        chk("rst_valid", {31'b0, o_valid}, 32'd0);
        chk("rst_instr", o_instr, 32'h0);
        chk("rst_pc", o_pc, 32'h0);

        // Release: request the cycle after, first word 2 cycles after first grant.
        rst_knob = 1'b0;
        step();
        chk("rel_req0", {31'b0, o_req}, 32'd0);
        step();
        chk("rel_req1", {31'b0, o_req}, 32'd1);
        chk("rel_addr", o_addr, 32'h0);
        step();
        chk("first_valid_early", {31'b0, o_valid}, 32'd0);
        step();
        chk("first_valid", {31'b0, o_valid}, 32'd1);
        chk("first_pc", o_pc, 32'h0);
        step();
        chk("stream_pc1", o_pc, 32'h4);
        step();
        chk("stream_pc2", o_pc, 32'h8);

        // Backpressure from reset: exactly four grants, then a held buffer.
        do_reset();
        rdy_pct = 0;
        steps(12);
        chk("bp_grants", grants, 32'd4);
        chk("bp_req", {31'b0, o_req}, 32'd0);
        chk("bp_head", o_pc, 32'h0);
        rdy_pct = 100;
        step();
        gnt_pct = 0;
        step();
        chk("bp_req_back", {31'b0, o_req}, 32'd1);
        chk("bp_next_pc", o_pc, 32'h4);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("gnt_hold_addr", o_addr, 32'h10);
        end
        gnt_pct = 100;

        // Redirect with words in flight and buffered.
        rv_pct  = 40;
        rdy_pct = 30;
        steps(6);
        force_redir = 1'b1;
        force_tgt   = 32'h0000_0103;
        step();
        step();
        chk("redir_valid_drop", {31'b0, o_valid}, 32'd0);
        rdy_pct = 100;
        wait_pop("redir_pop");
        chk("redir_pc", last_pop_pc, 32'h0000_0100);
        chk("redir_instr", last_pop_instr, 32'hDEAD_BFEF);

        // Back-to-back redirects: the last target wins.
        rv_pct = 100;
        steps(5);
        force_redir = 1'b1;
        force_tgt   = 32'h0000_0180;
        step();
        force_redir = 1'b1;
        force_tgt   = 32'h0000_0200;
        step();
        wait_pop("b2b_pop");
        chk("b2b_pc", last_pop_pc, 32'h0000_0200);

        // Single-cycle reset mid-stream.
        steps(4);
        rst_knob = 1'b1;
        step();
        rst_knob = 1'b0;
        step();
        chk("mid_rst_valid", {31'b0, o_valid}, 32'd0);
        chk("mid_rst_req", {31'b0, o_req}, 32'd0);
        wait_pop("mid_rst_pop");
        chk("mid_rst_pc", last_pop_pc, RPC);

        // Randomized traffic.
        redir_pm = 20;
        rst_pm   = 3;
        for (int blk = 0; blk < 20; blk++) begin
            gnt_pct = $urandom_range(20, 100);
            rv_pct  = $urandom_range(20, 100);
            rdy_pct = $urandom_range(10, 100);
            steps(200);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage of the RV32I core; sits directly upstream of decode.
- Owns the PC and issues word requests to instruction memory over a req/gnt/rvalid interface.
- Buffers returned words with their PCs in a small FIFO and presents them to decode over a valid/ready handshake; decode slices opcode = instr[6:0] for the main decoder.
- Accepts a redirect (taken branch / jal) from execute: retargets the PC, flushes buffered words and drops in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned)
FIFO_DEPTH, 4, instruction buffer entries; also the bound on outstanding + buffered words (power of two, >=2)

Ports:
clk  input  1  clock, all state updates on rising edge
rstn  input  1  synchronous active-low reset
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch address (always word aligned)
imem_gnt  input  1  request accepted this cycle (meaningful only with imem_req)
imem_rvalid  input  1  read data valid; responses return in request order, at least 1 cycle after gnt
imem_rdata  input  32  instruction word
redirect  input  1  flush and retarget
redirect_pc  input  32  new PC; bits [1:0] ignored (treated as 00)
instr_valid  output  1  instr/instr_pc hold a valid instruction
instr  output  32  instruction word to decode
instr_pc  output  32  address of instr
instr_ready  input  1  decode accepts the instruction

Behaviour:
- Reset (rstn=0 at a clock edge): pc_q=RESET_PC, resp_pc_q=RESET_PC, outstanding=0, discard_cnt=0, FIFO empty, req_en_q=0. Outputs during and right after reset: imem_req=0, instr_valid=0, instr=0, instr_pc=0 when empty.
- req_en_q is set 1 on the first edge with rstn=1, so imem_req rises the cycle after reset release.
- Request rule: imem_req = req_en_q & !redirect & (outstanding + fifo_count < FIFO_DEPTH). Uses registered counts only; a pop in the same cycle is not credited until the next cycle.
- imem_addr = {pc_q[31:2],2'b00}, stable while imem_req is held without gnt.
- On imem_req & imem_gnt: pc_q += 4 (wraps mod 2^32), outstanding += 1.
- On imem_rvalid:
  - outstanding -= 1.
  - If discard_cnt > 0: discard_cnt -= 1 and the word is dropped.
  - Else push {imem_rdata, resp_pc_q} and resp_pc_q += 4.
- Same-cycle gnt and rvalid: outstanding is unchanged.
- Push latency: a word with rvalid in cycle N appears on instr at N+1 (no combinational rdata->instr path).
- Output: instr_valid = FIFO non-empty; instr/instr_pc = head entry. Pop on instr_valid & instr_ready.
- Once valid, instr/instr_pc stay stable until popped. Only a redirect may withdraw them.
- Push and pop in the same cycle are both allowed, including when the FIFO is full (the credit rule makes full+push without pop impossible).
- Redirect has top priority in its cycle:
  - imem_req forced 0.
  - FIFO cleared; any same-cycle pop or push is ignored.
  - pc_q = resp_pc_q = {redirect_pc[31:2],2'b00}.
  - discard_cnt = outstanding after accounting for any same-cycle rvalid. A word arriving in the redirect cycle is always dropped.
  - instr_valid is 0 the next cycle.
- Back-to-back redirects: each recomputes discard_cnt from the current outstanding; the last target wins.
- Fetching resumes the cycle after redirect; new words are pushed only after discard_cnt reaches 0.
- Protocol checks (simulation assertions): rvalid with outstanding==0; fifo_count > FIFO_DEPTH; imem_addr[1:0] != 0.
- Reset mid-operation clears all counters. The memory is reset on the same rstn, so no pre-reset responses are delivered.

Test Plan:
- Reset release with gnt=1, rvalid 1 cycle after gnt, ready=1 -> imem_req=1 with addr 0x0 the cycle after release; instr_valid first high 2 cycles after first gnt; instr_pc 0x0,0x4,0x8,... one per cycle with no bubbles.
- instr_ready=0 while streaming -> exactly 4 grants (0x0..0xC) then imem_req=0; FIFO holds 0x0,0x4,0x8,0xC stable. Ready=1 -> drains in order, one per cycle; imem_req re-asserts the cycle after the first pop.
- imem_gnt low 3 cycles -> imem_addr held 0x10 throughout; no PC advance.
- Redirect to 0x0000_0103 with 2 outstanding and 1 buffered -> FIFO cleared; the next 2 rvalid words are dropped; first instr_pc after redirect = 0x100, with instr equal to the rdata returned for addr 0x100.
- Redirect in the same cycle as rvalid and pop, then a second redirect to 0x200 next cycle -> no stale word delivered; first instr_pc = 0x200.
- rstn=0 for one cycle mid-stream -> the next cycle instr_valid=0 and imem_req=0; refetch starts at RESET_PC.
